// File: rtl/tych_ingr_chk_pkg.sv
// Shared core stream structures for the tych datapath.
// Contents:
//   core_avl_t     - one Avalon-ST style beat (valid/sop/eop/error/data/empty/frm_dbg_id)
//   FRM_DBG_ID_W   - width of the per-packet debug identifier
//   MAX_BEATS_DEF  - default maximum packet length used by tych_ingr_chk
//   ingr_state_e   - per-lane packet-checker FSM states
package tych_ingr_chk_pkg;

   localparam int DATA_W        = 32;
   localparam int EMPTY_W       = 2;
   localparam int FRM_DBG_ID_W  = 4;
   localparam int MAX_BEATS_DEF = 256;

   typedef struct packed {
      logic                    valid;
      logic                    sop;
      logic                    eop;
      logic                    error;
      logic [DATA_W-1:0]       data;
      logic [EMPTY_W-1:0]      empty;
      logic [FRM_DBG_ID_W-1:0] frm_dbg_id;
   } core_avl_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_IN_PKT = 2'd1,
      ST_DROP   = 2'd2
   } ingr_state_e;

endpackage

// File: rtl/tych_ingr_chk_lane.sv
// One lane of the ingress framing checker.
// Checks sop/eop framing and packet length on accepted beats, repairs or
// discards malformed traffic, stamps a per-packet debug id and buffers the
// result in a 2-entry skid buffer.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   i_in            - upstream beat
//   o_inReady       - registered ready to upstream
//   o_out           - checked beat towards the forwarder
//   i_outReady      - ready from the forwarder
//   o_dropCnt       - saturating count of discarded beats
//   o_errCnt        - saturating count of packets terminated with error
module tych_ingr_chk_lane
   import tych_ingr_chk_pkg::*;
#(
   parameter int MAX_BEATS = MAX_BEATS_DEF,
   parameter int STAT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  core_avl_t         i_in,
   output logic              o_inReady,
   output core_avl_t         o_out,
   input  logic              i_outReady,
   output logic [STAT_W-1:0] o_dropCnt,
   output logic [STAT_W-1:0] o_errCnt
);

   localparam int CNT_W = $clog2(MAX_BEATS);

   ingr_state_e             r_state;
   ingr_state_e             w_nextState;
   logic [CNT_W-1:0]        r_beatCnt;
   logic [CNT_W-1:0]        w_nextBeatCnt;
   logic                    r_inReady;
   core_avl_t               r_buf [2];
   logic                    r_wrPtr;
   logic                    r_rdPtr;
   logic [1:0]              r_count;
   logic [1:0]              w_countNext;
   logic [FRM_DBG_ID_W-1:0] r_idNext;
   logic [FRM_DBG_ID_W-1:0] r_idCur;
   logic [STAT_W-1:0]       r_dropCnt;
   logic [STAT_W-1:0]       r_errCnt;

   logic                    w_accept;
   logic                    w_fwd;
   logic                    w_drop;
   logic                    w_errGen;
   logic                    w_newPkt;
   logic                    w_push;
   logic                    w_pop;
   core_avl_t               w_beat;

   assign w_accept = i_in.valid & r_inReady;

   // Framing decision for the beat being accepted this cycle, plus the
   // (possibly repaired) beat that enters the skid buffer.
   always_comb begin
      w_nextState   = r_state;
      w_nextBeatCnt = r_beatCnt;
      w_fwd         = 1'b0;
      w_drop        = 1'b0;
      w_errGen      = 1'b0;
      w_newPkt      = 1'b0;
      w_beat        = i_in;
      if (w_accept) begin
         case (r_state)
            ST_IDLE: begin
               if (i_in.sop) begin
                  w_fwd    = 1'b1;
                  w_newPkt = 1'b1;
                  if (!i_in.eop) begin
                     w_nextBeatCnt = CNT_W'(1);
                     w_nextState   = ST_IN_PKT;
                  end
               end else begin
                  w_drop = 1'b1;
               end
            end
            ST_IN_PKT: begin
               w_fwd = 1'b1;
               if (i_in.sop) begin
                  // A second sop closes the current packet rather than
                  // starting a new one.
                  w_beat.sop  = 1'b0;
                  w_beat.eop  = 1'b1;
                  w_errGen    = 1'b1;
                  w_nextState = ST_IDLE;
               end else if (i_in.eop) begin
                  w_nextState = ST_IDLE;
               end else if (r_beatCnt == CNT_W'(MAX_BEATS - 1)) begin
                  // Length limit reached: truncate here and discard the tail.
                  w_beat.eop  = 1'b1;
                  w_errGen    = 1'b1;
                  w_nextState = ST_DROP;
               end else begin
                  w_nextBeatCnt = r_beatCnt + CNT_W'(1);
               end
            end
            ST_DROP: begin
               w_drop = 1'b1;
               if (i_in.eop) begin
                  w_nextState = ST_IDLE;
               end
            end
            default: begin
               w_nextState = ST_IDLE;
            end
         endcase
      end
      w_beat.error      = i_in.error | w_errGen;
      w_beat.frm_dbg_id = w_newPkt ? r_idNext : r_idCur;
   end

   assign w_push = w_fwd;
   assign w_pop  = (r_count != 2'd0) & i_outReady;

   // Skid buffer occupancy after this cycle's push/pop.
   always_comb begin
      w_countNext = r_count;
      case ({w_push, w_pop})
         2'b10:   w_countNext = r_count + 2'd1;
         2'b01:   w_countNext = r_count - 2'd1;
         default: w_countNext = r_count;
      endcase
   end

   // FSM state and beat counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_beatCnt <= '0;
      end else begin
         r_state   <= w_nextState;
         r_beatCnt <= w_nextBeatCnt;
      end
   end

   // Skid buffer storage; ready is registered from the next occupancy so it
   // never depends combinationally on the downstream ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf[0]  <= '0;
         r_buf[1]  <= '0;
         r_wrPtr   <= 1'b0;
         r_rdPtr   <= 1'b0;
         r_count   <= 2'd0;
         r_inReady <= 1'b0;
      end else begin
         if (w_push) begin
            r_buf[r_wrPtr] <= w_beat;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (w_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         r_count   <= w_countNext;
         r_inReady <= (w_countNext <= 2'd1);
      end
   end

   // Debug id: r_idCur holds the id of the packet in flight, r_idNext the id
   // the next forwarded sop will take.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idNext <= '0;
         r_idCur  <= '0;
      end else if (w_newPkt) begin
         r_idCur  <= r_idNext;
         r_idNext <= r_idNext + FRM_DBG_ID_W'(1);
      end
   end

   // Saturating statistics.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dropCnt <= '0;
         r_errCnt  <= '0;
      end else begin
         if (w_drop && (r_dropCnt != '1)) begin
            r_dropCnt <= r_dropCnt + STAT_W'(1);
         end
         if (w_errGen && (r_errCnt != '1)) begin
            r_errCnt <= r_errCnt + STAT_W'(1);
         end
      end
   end

   assign o_inReady = r_inReady;
   assign o_out     = (r_count != 2'd0) ? r_buf[r_rdPtr] : '0;
   assign o_dropCnt = r_dropCnt;
   assign o_errCnt  = r_errCnt;

endmodule

// File: rtl/tych_ingr_chk.sv
// Ingress framing checker in front of tych_fwd.
// Replicates one independent checker lane per port.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   core_avl_in         - upstream stream per lane
//   core_avl_in_ready   - per-lane ready to upstream
//   core_avl_out        - checked stream per lane
//   core_avl_out_ready  - per-lane ready from tych_fwd
//   stat_drop_cnt       - per-lane discarded-beat counters
//   stat_err_cnt        - per-lane error-terminated-packet counters
module tych_ingr_chk
   import tych_ingr_chk_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int MAX_BEATS = MAX_BEATS_DEF,
   parameter int STAT_W    = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  core_avl_t [NUM_PORTS-1:0]        core_avl_in,
   output logic [NUM_PORTS-1:0]             core_avl_in_ready,
   output core_avl_t [NUM_PORTS-1:0]        core_avl_out,
   input  logic [NUM_PORTS-1:0]             core_avl_out_ready,
   output logic [NUM_PORTS-1:0][STAT_W-1:0] stat_drop_cnt,
   output logic [NUM_PORTS-1:0][STAT_W-1:0] stat_err_cnt
);

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
      tych_ingr_chk_lane #(
         .MAX_BEATS (MAX_BEATS),
         .STAT_W    (STAT_W)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .i_in       (core_avl_in[g]),
         .o_inReady  (core_avl_in_ready[g]),
         .o_out      (core_avl_out[g]),
         .i_outReady (core_avl_out_ready[g]),
         .o_dropCnt  (stat_drop_cnt[g]),
         .o_errCnt   (stat_err_cnt[g])
      );
   end

endmodule

// File: tb/tb_tych_ingr_chk.sv
// Self-checking bench for tych_ingr_chk (2 lanes, MAX_BEATS=4, STAT_W=4).
// Expected beats are pushed into per-lane queues when stimulus is issued;
// a monitor pops and compares every beat the DUT transfers.
module tb_tych_ingr_chk;
   import tych_ingr_chk_pkg::*;

   localparam int NP = 2;
   localparam int MB = 4;
   localparam int SW = 4;

   logic                     clk = 1'b0;
   logic                     rst;
   core_avl_t [NP-1:0]       tbIn;
   logic [NP-1:0]            inReady;
   core_avl_t [NP-1:0]       dutOut;
   logic [NP-1:0]            outReady;
   logic [NP-1:0][SW-1:0]    dropCnt;
   logic [NP-1:0][SW-1:0]    errCnt;

   int checkCount = 0;
   int passCount  = 0;

   core_avl_t expQ0[$];
   core_avl_t expQ1[$];

   tych_ingr_chk #(
      .NUM_PORTS (NP),
      .MAX_BEATS (MB),
      .STAT_W    (SW)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .core_avl_in        (tbIn),
      .core_avl_in_ready  (inReady),
      .core_avl_out       (dutOut),
      .core_avl_out_ready (outReady),
      .stat_drop_cnt      (dropCnt),
      .stat_err_cnt       (errCnt)
   );

   always #5 clk = ~clk;

   // One comparison; every check in the bench goes through here.
   task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic core_avl_t mkBeat(logic sop, logic eop, logic err,
                                        logic [31:0] data, logic [3:0] id);
      core_avl_t b;
      b            = '0;
      b.valid      = 1'b1;
      b.sop        = sop;
      b.eop        = eop;
      b.error      = err;
      b.data       = data;
      b.empty      = data[1:0];
      b.frm_dbg_id = id;
      return b;
   endfunction

   task automatic expectBeat(int lane, logic sop, logic eop, logic err,
                             logic [31:0] data, logic [3:0] id);
      if (lane == 0) expQ0.push_back(mkBeat(sop, eop, err, data, id));
      else           expQ1.push_back(mkBeat(sop, eop, err, data, id));
   endtask

   // Presents one beat (input frm_dbg_id deliberately garbage) until accepted.
   task automatic applyStimulus(int lane, logic sop, logic eop, logic err,
                                logic [31:0] data);
      bit done;
      done       = 1'b0;
      tbIn[lane] = mkBeat(sop, eop, err, data, 4'hF);
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (inReady[lane]) done = 1'b1;
         @(posedge clk);
         #1;
      end
      tbIn[lane] = '0;
      checkOutput($sformatf("accept_l%0d_%0h", lane, data), 64'(done), 64'(1));
   endtask

   task automatic waitDrain();
      for (int c = 0; c < 50; c++) begin
         if (expQ0.size() == 0 && expQ1.size() == 0) break;
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      checkOutput("drain", 64'(expQ0.size() + expQ1.size()), 64'(0));
   endtask

   // Monitor: a beat transfers at the next posedge when valid and ready are
   // both high at the negedge.
   initial begin
      core_avl_t e;
      forever begin
         @(negedge clk);
         for (int l = 0; l < NP; l++) begin
            if (dutOut[l].valid && outReady[l]) begin
               if ((l == 0 && expQ0.size() == 0) || (l == 1 && expQ1.size() == 0)) begin
                  checkOutput($sformatf("lane%0d_unexpected", l), 64'(dutOut[l]), 64'(0));
               end else begin
                  e = (l == 0) ? expQ0.pop_front() : expQ1.pop_front();
                  checkOutput($sformatf("lane%0d_beat_%0h", l, e.data), 64'(dutOut[l]), 64'(e));
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst      = 1'b0;
      tbIn     = '0;
      outReady = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", 64'(inReady), 64'(0));
      checkOutput("reset_out_valid", 64'({dutOut[1].valid, dutOut[0].valid}), 64'(0));
      checkOutput("reset_drop", 64'(dropCnt), 64'(0));
      checkOutput("reset_err", 64'(errCnt), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("in_ready_at_release", 64'(inReady), 64'(0));
      @(posedge clk);
      #1;
      checkOutput("in_ready_rise", 64'(inReady), 64'(2'b11));

      // 3-beat packet on lane 0
      $display("[TB] test: basic 3-beat packet");
      expectBeat(0, 1, 0, 0, 32'hA1, 4'd0);
      expectBeat(0, 0, 0, 0, 32'hA2, 4'd0);
      expectBeat(0, 0, 1, 0, 32'hA3, 4'd0);
      applyStimulus(0, 1, 0, 0, 32'hA1);
      checkOutput("first_latency", 64'(dutOut[0].valid), 64'(1));
      applyStimulus(0, 0, 0, 0, 32'hA2);
      applyStimulus(0, 0, 1, 0, 32'hA3);
      waitDrain();

      // stray beat in IDLE then single-beat packet on lane 1
      $display("[TB] test: stray beat then single-beat packet");
      expectBeat(1, 1, 1, 0, 32'hB1, 4'd0);
      applyStimulus(1, 0, 0, 0, 32'hB0);
      applyStimulus(1, 1, 1, 0, 32'hB1);
      waitDrain();
      checkOutput("l1_drop_stray", 64'(dropCnt[1]), 64'(1));
      checkOutput("l1_err_stray", 64'(errCnt[1]), 64'(0));

      // missing eop on lane 0
      $display("[TB] test: missing eop");
      expectBeat(0, 1, 0, 0, 32'hC1, 4'd1);
      expectBeat(0, 0, 0, 0, 32'hC2, 4'd1);
      expectBeat(0, 0, 1, 1, 32'hC3, 4'd1);
      applyStimulus(0, 1, 0, 0, 32'hC1);
      applyStimulus(0, 0, 0, 0, 32'hC2);
      applyStimulus(0, 1, 0, 0, 32'hC3);
      waitDrain();
      checkOutput("l0_err_missing_eop", 64'(errCnt[0]), 64'(1));
      checkOutput("l0_drop_missing_eop", 64'(dropCnt[0]), 64'(0));

      // overlong packet: 6 beats with MAX_BEATS=4
      $display("[TB] test: overlong packet");
      expectBeat(0, 1, 0, 0, 32'hD1, 4'd2);
      expectBeat(0, 0, 0, 0, 32'hD2, 4'd2);
      expectBeat(0, 0, 0, 0, 32'hD3, 4'd2);
      expectBeat(0, 0, 1, 1, 32'hD4, 4'd2);
      applyStimulus(0, 1, 0, 0, 32'hD1);
      applyStimulus(0, 0, 0, 0, 32'hD2);
      applyStimulus(0, 0, 0, 0, 32'hD3);
      applyStimulus(0, 0, 0, 0, 32'hD4);
      applyStimulus(0, 0, 0, 0, 32'hD5);
      applyStimulus(0, 0, 1, 0, 32'hD6);
      waitDrain();
      checkOutput("l0_drop_overlong", 64'(dropCnt[0]), 64'(2));
      checkOutput("l0_err_overlong", 64'(errCnt[0]), 64'(2));
      // next packet normal; input error passes through without counting
      expectBeat(0, 1, 0, 0, 32'hE1, 4'd3);
      expectBeat(0, 0, 1, 1, 32'hE2, 4'd3);
      applyStimulus(0, 1, 0, 0, 32'hE1);
      applyStimulus(0, 0, 1, 1, 32'hE2);
      waitDrain();
      checkOutput("l0_err_after_pass", 64'(errCnt[0]), 64'(2));

      // backpressure on lane 1
      $display("[TB] test: backpressure");
      begin
         core_avl_t fBeats [4];
         int idx;
         int acc;
         bit took;
         fBeats[0] = mkBeat(1, 0, 0, 32'hF1, 4'hF);
         fBeats[1] = mkBeat(0, 0, 0, 32'hF2, 4'hF);
         fBeats[2] = mkBeat(0, 0, 0, 32'hF3, 4'hF);
         fBeats[3] = mkBeat(0, 1, 0, 32'hF4, 4'hF);
         expectBeat(1, 1, 0, 0, 32'hF1, 4'd1);
         expectBeat(1, 0, 0, 0, 32'hF2, 4'd1);
         expectBeat(1, 0, 0, 0, 32'hF3, 4'd1);
         expectBeat(1, 0, 1, 0, 32'hF4, 4'd1);
         outReady[1] = 1'b0;
         idx = 0;
         acc = 0;
         tbIn[1] = fBeats[0];
         for (int c = 0; c < 8; c++) begin
            took = 1'b0;
            @(negedge clk);
            if (inReady[1]) begin
               acc++;
               took = 1'b1;
            end
            @(posedge clk);
            #1;
            if (took) begin
               idx++;
               tbIn[1] = (idx < 4) ? fBeats[idx] : '0;
            end
         end
         checkOutput("bp_accepted", 64'(acc), 64'(2));
         checkOutput("bp_in_ready_low", 64'(inReady[1]), 64'(0));
         outReady[1] = 1'b1;
         applyStimulus(1, 0, 0, 0, 32'hF3);
         applyStimulus(1, 0, 1, 0, 32'hF4);
         waitDrain();
      end

      // drop counter saturation on lane 1 (1 + 17 drops, max 15)
      $display("[TB] test: drop counter saturation");
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1, 0, 0, 0, 32'h100 + i);
      end
      checkOutput("l1_drop_saturated", 64'(dropCnt[1]), 64'(15));
      checkOutput("l0_drop_untouched", 64'(dropCnt[0]), 64'(2));

      // reset in the middle of a packet on lane 0
      $display("[TB] test: reset mid-packet");
      expectBeat(0, 1, 0, 0, 32'h61, 4'd4);
      expectBeat(0, 0, 0, 0, 32'h62, 4'd4);
      applyStimulus(0, 1, 0, 0, 32'h61);
      applyStimulus(0, 0, 0, 0, 32'h62);
      waitDrain();
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("mid_reset_out_valid", 64'({dutOut[1].valid, dutOut[0].valid}), 64'(0));
      checkOutput("mid_reset_in_ready", 64'(inReady), 64'(0));
      checkOutput("mid_reset_drop", 64'(dropCnt), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(0, 0, 1, 0, 32'h71);
      @(posedge clk);
      #1;
      checkOutput("post_reset_drop", 64'(dropCnt), 64'({4'd0, 4'd1}));
      checkOutput("post_reset_err", 64'(errCnt), 64'(0));
      expectBeat(0, 1, 1, 0, 32'h81, 4'd0);
      applyStimulus(0, 1, 1, 0, 32'h81);
      waitDrain();

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/tych_ingr_chk.md
TYCH_INGR_CHK -- requirements
Module: tych_ingr_chk

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of independent lanes, equal to the downstream tych_fwd NUM_PORTS.
REQ-002 Parameter MAX_BEATS, default 256: maximum beats per packet, sop and eop beats included.
REQ-003 Parameter STAT_W, default 16: width of each statistics counter.
REQ-004 Port clk, input, 1: the single clock; all logic is in this domain.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port core_avl_in, input, core_avl_t[NUM_PORTS]: upstream stream per lane.
REQ-007 Port core_avl_in_ready, output, [NUM_PORTS]: per-lane ready to upstream.
REQ-008 Port core_avl_out, output, core_avl_t[NUM_PORTS]: checked stream, feeds tych_fwd core_avl_in.
REQ-009 Port core_avl_out_ready, input, [NUM_PORTS]: per-lane ready from tych_fwd.
REQ-010 Port stat_drop_cnt, output, [NUM_PORTS][STAT_W]: beats discarded, per lane.
REQ-011 Port stat_err_cnt, output, [NUM_PORTS][STAT_W]: packets terminated with error, per lane.

Function
REQ-012 Lanes SHALL be fully independent; no cross-lane state.
REQ-013 Input accept SHALL occur when in.valid=1 and in_ready=1; output transfer SHALL occur when out.valid=1 and out_ready=1.
REQ-014 Each lane SHALL have a 2-entry output skid buffer.
REQ-015 in_ready SHALL be registered and equal 1 iff the skid buffer holds at most 1 entry; it SHALL NOT depend combinationally on out_ready.
REQ-016 Latency SHALL be 1 cycle from accept to out.valid when the buffer is empty.
REQ-017 Order SHALL be preserved; simultaneous push and pop on a full buffer SHALL be legal and keep occupancy constant.
REQ-018 Each lane SHALL run an FSM with states IDLE, IN_PKT and DROP, evaluated only on accepted beats.
REQ-019 IDLE, sop=1, eop=1: forward unchanged as a single-beat packet; stay in IDLE.
REQ-020 IDLE, sop=1, eop=0: forward; load beat count to 1; go to IN_PKT.
REQ-021 IDLE, sop=0: discard the beat; stat_drop_cnt++; stay in IDLE.
REQ-022 IN_PKT, sop=0, eop=1: forward; go to IDLE.
REQ-023 IN_PKT, sop=1 (missing eop): forward the beat as sop=0, eop=1, error=1; stat_err_cnt++; go to IDLE. The beat is not treated as a new packet start.
REQ-024 IN_PKT, sop=0, eop=0, beat count=MAX_BEATS-1: forward the beat as eop=1, error=1; stat_err_cnt++; go to DROP.
REQ-025 IN_PKT, sop=0, eop=0, beat count below MAX_BEATS-1: forward; increment the count; stay in IN_PKT.
REQ-026 DROP: discard every beat and increment stat_drop_cnt per beat; the beat with eop=1 returns the FSM to IDLE, and sop is ignored.
REQ-027 Discarded beats SHALL still be accepted (in_ready rule unchanged) and SHALL NOT enter the skid buffer.
REQ-028 data, empty and valid SHALL pass unmodified.
REQ-029 Output error SHALL be the input error OR-ed with any check-generated error.
REQ-030 frm_dbg_id SHALL be overwritten by a per-lane counter that increments on each forwarded sop beat and wraps modulo 2^FRM_DBG_ID_W.
REQ-031 The frm_dbg_id value SHALL be held for every beat of its packet; the first packet after reset carries 0.
REQ-032 Statistics counters SHALL saturate at 2^STAT_W-1 and never wrap.

Reset
REQ-033 On rst=0, asynchronously: FSM=IDLE, beat count=0, skid buffer empty, out.valid=0, in_ready=0, frm_dbg_id counter=0, stat counters=0.
REQ-034 in_ready SHALL rise 1 cycle after rst deasserts.
REQ-035 A packet interrupted by reset SHALL be abandoned with no eop emitted; the next accepted beat is judged from IDLE.

Structure
REQ-036 core_avl_t and FRM_DBG_ID_W SHALL come from the shared core structures package.
REQ-037 The FSM state enum and the default MAX_BEATS constant SHALL be added to that package.
REQ-038 Per-lane logic SHALL live in sub-module tych_ingr_chk_lane, replicated by a generate loop over NUM_PORTS.

Verification
REQ-039 Lane 0 sends 3-beat packet (sop, -, eop), out_ready=1 -> 3 output beats, frm_dbg_id=0, error=0, first output 1 cycle after first accept.
REQ-040 Lane 1 sends beat sop=0 in IDLE, then single-beat packet sop=eop=1 -> stat_drop_cnt[1]=1; only the single-beat packet appears, with frm_dbg_id=0.
REQ-041 Lane 0 sends sop, data, then sop again -> third output beat has sop=0, eop=1, error=1; stat_err_cnt[0]=1.
REQ-042 MAX_BEATS=4; send 6-beat packet -> 4th output beat has eop=1, error=1; beats 5-6 dropped; stat_drop_cnt=2; next packet is forwarded normally.
REQ-043 out_ready held 0 with continuous input -> exactly 2 beats accepted, then in_ready=0; release -> no loss, no duplication, order kept.
REQ-044 Assert rst mid-packet, release, then send eop-only beat -> beat dropped, all counters equal 1 drop and 0 errors, outputs idle during reset.
